// File: rtl/ads_pkg.sv
// Shared constants for the ADS1220 sample FIFO: sample width and host register map.
package ads_pkg;
  localparam int unsigned ADS_W = 24;

  localparam logic [7:0] ADDR_LEVEL    = 8'd0;
  localparam logic [7:0] ADDR_STAT     = 8'd1;
  localparam logic [7:0] ADDR_LO       = 8'd2;
  localparam logic [7:0] ADDR_HI_POP   = 8'd3;
  localparam logic [7:0] ADDR_STAT_CLR = 8'd4;
endpackage

// File: rtl/ads_sample_ram.sv
// Simple dual-port sample store: synchronous write, registered read, storage not reset.
module ads_sample_ram #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned W          = 24
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [W-1:0]          wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [W-1:0]          rdata
);
  logic [W-1:0] mem [1 << DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/ads_sample_fifo.sv
// Averages ADS1220 conversions and buffers the averages in a circular FIFO
// that the MSP430 drains over the datacs/RDdata/dataAddr/outrddat read bus.
module ads_sample_fifo
  import ads_pkg::*;
#(
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic              CLK_50M,
  input  logic              rst_n,
  input  logic [ADS_W-1:0]  smp_dat,
  input  logic              smp_vld,
  input  logic              clr,
  input  logic              datacs,
  input  logic              RDdata,
  input  logic [11:0]       dataAddr,
  output logic [15:0]       outrddat,
  output logic              data_rdy
);
  localparam int unsigned AW    = ADS_W + AVG_LOG2;
  localparam int unsigned NAVG  = 1 << AVG_LOG2;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic signed [AW-1:0]  acc, sext, sum;
  logic [4:0]            cnt;
  logic [ADS_W-1:0]      avg_q, rdata;
  logic                  wr_pend;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [DEPTH_LOG2:0]   level, level_nxt;
  logic                  ovf, udf, ovf_nxt, udf_nxt;
  logic                  acc_stb, stb_q, host_edge, edge_q;
  logic [7:0]            addr_q;
  logic                  empty, full, pop, stat_clr;
  logic [15:0]           rd_val;
  logic                  addr_unused;

  assign addr_unused = &{1'b0, dataAddr[11:8]};

  assign sext = AW'($signed(smp_dat));
  assign sum  = acc + sext;

  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      avg_q   <= '0;
      wr_pend <= 1'b0;
    end else if (clr) begin
      acc     <= '0;
      cnt     <= '0;
      wr_pend <= 1'b0;
    end else begin
      wr_pend <= 1'b0;
      if (smp_vld) begin
        if (cnt == 5'(NAVG - 1)) begin
          acc     <= '0;
          cnt     <= '0;
          avg_q   <= ADS_W'(sum >>> AVG_LOG2);
          wr_pend <= 1'b1;
        end else begin
          acc <= sum;
          cnt <= cnt + 5'd1;
        end
      end
    end
  end

  assign acc_stb   = datacs & RDdata;
  assign host_edge = acc_stb & ~stb_q;

  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      stb_q  <= 1'b0;
      edge_q <= 1'b0;
      addr_q <= '0;
    end else begin
      stb_q  <= acc_stb;
      edge_q <= host_edge;
      if (host_edge) addr_q <= dataAddr[7:0];
    end
  end

  assign empty    = (level == '0);
  assign full     = (level == (DEPTH_LOG2 + 1)'(DEPTH));
  assign pop      = edge_q && (addr_q == ADDR_HI_POP);
  assign stat_clr = edge_q && (addr_q == ADDR_STAT_CLR);

  // A write into a full buffer retires the oldest entry unless the host pops in
  // the same cycle, in which case the pop supplies the free slot and ovf stays clear.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    level_nxt  = level;
    ovf_nxt    = stat_clr ? 1'b0 : ovf;
    udf_nxt    = stat_clr ? 1'b0 : udf;
    if (clr) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      level_nxt  = '0;
      ovf_nxt    = 1'b0;
      udf_nxt    = 1'b0;
    end else begin
      if (pop && empty) udf_nxt = 1'b1;
      if (wr_pend) begin
        wr_ptr_nxt = wr_ptr + 1'b1;
        if (pop && !empty) begin
          rd_ptr_nxt = rd_ptr + 1'b1;
        end else if (full) begin
          rd_ptr_nxt = rd_ptr + 1'b1;
          ovf_nxt    = 1'b1;
        end else begin
          level_nxt = level + 1'b1;
        end
      end else if (pop && !empty) begin
        rd_ptr_nxt = rd_ptr + 1'b1;
        level_nxt  = level - 1'b1;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (addr_q)
      ADDR_LEVEL:              rd_val = 16'(level);
      ADDR_STAT, ADDR_STAT_CLR: rd_val = {14'd0, udf, ovf};
      ADDR_LO:                 rd_val = empty ? 16'd0 : rdata[15:0];
      ADDR_HI_POP:             rd_val = empty ? 16'd0 : {{8{rdata[23]}}, rdata[23:16]};
      default:                 rd_val = '0;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      outrddat <= '0;
      data_rdy <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      level    <= level_nxt;
      ovf      <= ovf_nxt;
      udf      <= udf_nxt;
      data_rdy <= (level_nxt != '0);
      if (edge_q) outrddat <= rd_val;
    end
  end

  ads_sample_ram #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .W         (ADS_W)
  ) u_ram (
    .clk  (CLK_50M),
    .we   (wr_pend & ~clr),
    .waddr(wr_ptr),
    .wdata(avg_q),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
endmodule
